// File: rtl/t07_mmio_bridge.sv
// Single-beat Wishbone-classic bridge between the CPU memory handler and MMIO.
// Optional ack timeout: define T07_BRIDGE_TIMEOUT_EN.
module t07_mmio_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  rwi,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic        is_fetch_o,
  output logic        err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;
  logic   req;
  logic   fetch_q;
  logic   abort;

  assign req   = (rwi != 2'b00);
  assign sel_o = 4'hF;

`ifdef T07_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  // Counter is held at zero in IDLE, so it starts fresh on WAIT_ACK entry
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (state == WAIT_ACK) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign abort = (state == WAIT_ACK) && !ack_i &&
                 (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign abort     = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (req) state_nx = WAIT_ACK;
      WAIT_ACK: if (ack_i || abort) state_nx = HOLD;
      HOLD:     if (!req) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    cyc_o  = 1'b0;
    stb_o  = 1'b0;
    busy_o = 1'b0;
    if (state == WAIT_ACK) begin
      cyc_o  = 1'b1;
      stb_o  = 1'b1;
      busy_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      adr_o      <= '0;
      dat_o      <= '0;
      we_o       <= 1'b0;
      fetch_q    <= 1'b0;
      rdata_o    <= '0;
      is_fetch_o <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        adr_o   <= addr_i;
        dat_o   <= wdata_i;
        we_o    <= (rwi == 2'b01);
        fetch_q <= (rwi == 2'b11);
      end
      if (state == WAIT_ACK && ack_i) begin
        if (!we_o) rdata_o <= dat_i;
        is_fetch_o <= fetch_q;
      end else if (abort && !we_o) begin
        rdata_o <= 32'hBAD0_BAD0;
      end
    end
  end

endmodule

// File: tb/tb_t07_mmio_bridge.sv
// Randomized self-checking bench for t07_mmio_bridge.
// Expectations come from a transaction-level model of the bridge.
module tb_t07_mmio_bridge;

`ifdef T07_BRIDGE_TIMEOUT_EN
  localparam int TO = 4;
  localparam int MAX_DLY = 3;
`else
  localparam int TO = 255;
  localparam int MAX_DLY = 6;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  rwi;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic [31:0] rdata_o;
  logic        is_fetch_o;
  logic        err_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rdata = '0;
  logic        exp_fetch = 1'b0;
  logic        exp_err   = 1'b0;

  always #5 clk = ~clk;

  t07_mmio_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nrst(nrst), .rwi(rwi),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .rdata_o(rdata_o),
    .is_fetch_o(is_fetch_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; rwi = 2'b00; ack_i = 1'b0;
    addr_i = '0; wdata_i = '0; dat_i = '0;
    tick(); tick();
    n_checks++;
    if ({cyc_o, stb_o, we_o, busy_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b exp=0000",
               {cyc_o, stb_o, we_o, busy_o});
    end
    n_checks++;
    if ({is_fetch_o, err_o} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=00",
               {is_fetch_o, err_o});
    end
    n_checks++;
    if ({adr_o, dat_o, rdata_o} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_data adr=%h dat=%h rdata=%h exp=0",
               adr_o, dat_o, rdata_o);
    end
    n_checks++;
    if (sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL sel got=%h exp=f", sel_o);
    end
    nrst = 1'b1;
    tick();
    exp_rdata = '0; exp_fetch = 1'b0; exp_err = 1'b0;
  endtask

  // One request: ack after dly WAIT_ACK cycles, request held hold cycles
  task automatic do_txn(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] d,
                        input int dly, input int hold);
    int busy_cnt;
    rwi = op; addr_i = a; wdata_i = w;
    ack_i = 1'b0; dat_i = $urandom;
    tick();
    n_checks++;
    if (adr_o !== a || dat_o !== w || we_o !== (op == 2'b01)) begin
      n_fail++;
      $display("FAIL latch adr=%h dat=%h we=%b exp %h %h %b",
               adr_o, dat_o, we_o, a, w, op == 2'b01);
    end
    busy_cnt = 0;
    for (int i = 0; i <= dly; i++) begin
      if (busy_o && cyc_o && stb_o) busy_cnt++;
      n_checks++;
      if (adr_o !== a || dat_o !== w) begin
        n_fail++;
        $display("FAIL hold_bus adr=%h dat=%h exp %h %h",
                 adr_o, dat_o, a, w);
      end
      addr_i  = $urandom;
      wdata_i = $urandom;
      ack_i   = (i == dly);
      dat_i   = (i == dly) ? d : $urandom;
      tick();
    end
    ack_i = 1'b0;
    if (op[1]) exp_rdata = d;
    exp_fetch = (op == 2'b11);
    n_checks++;
    if (busy_cnt !== dly + 1 || busy_o !== 1'b0 || cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_len got=%0d busy=%b exp=%0d busy=0",
               busy_cnt, busy_o, dly + 1);
    end
    n_checks++;
    if (rdata_o !== exp_rdata || is_fetch_o !== exp_fetch) begin
      n_fail++;
      $display("FAIL result rdata=%h fetch=%b exp %h %b",
               rdata_o, is_fetch_o, exp_rdata, exp_fetch);
    end
    n_checks++;
    if (err_o !== exp_err) begin
      n_fail++;
      $display("FAIL err got=%b exp=%b", err_o, exp_err);
    end
    for (int i = 0; i < hold; i++) begin
      ack_i = $urandom_range(0, 1);
      dat_i = $urandom;
      tick();
      n_checks++;
      if (cyc_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== exp_rdata) begin
        n_fail++;
        $display("FAIL reissue cyc=%b busy=%b rdata=%h exp 0 0 %h",
                 cyc_o, busy_o, rdata_o, exp_rdata);
      end
    end
    ack_i = 1'b0;
    rwi = 2'b00;
    tick();
  endtask

  task automatic test_fetch_immediate();
    do_txn(2'b11, 32'h100, $urandom, 32'h0050_0093, 0, 0);
  endtask

  task automatic test_write_delayed();
    do_txn(2'b01, 32'h2000, 32'hCAFE_F00D, $urandom, 3, 0);
  endtask

  task automatic test_held_request();
    do_txn(2'b10, 32'h3000, $urandom, 32'h1234_5678, 1, 6);
  endtask

  task automatic test_addr_change();
    do_txn(2'b10, 32'h4444_0000, $urandom, $urandom, MAX_DLY, 1);
  endtask

  task automatic test_reset_mid();
    rwi = 2'b10; addr_i = 32'h5000; wdata_i = $urandom;
    tick();
    nrst = 1'b0; ack_i = 1'b1; dat_i = 32'hDEAD_BEEF;
    tick();
    nrst = 1'b1; ack_i = 1'b0; rwi = 2'b00;
    exp_rdata = '0; exp_fetch = 1'b0; exp_err = 1'b0;
    n_checks++;
    if ({cyc_o, stb_o, we_o, busy_o, is_fetch_o, err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ctl got=%b exp=000000",
               {cyc_o, stb_o, we_o, busy_o, is_fetch_o, err_o});
    end
    n_checks++;
    if ({adr_o, dat_o, rdata_o} !== 96'b0) begin
      n_fail++;
      $display("FAIL rst_mid_data adr=%h dat=%h rdata=%h exp=0",
               adr_o, dat_o, rdata_o);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_idle busy=%b exp=0", busy_o);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int k = 0; k < 25; k++) begin
      op = 2'($urandom_range(1, 3));
      do_txn(op, $urandom, $urandom, $urandom,
             $urandom_range(0, MAX_DLY), $urandom_range(0, 3));
    end
  endtask

`ifdef T07_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    rwi = 2'b10; addr_i = 32'h6000; ack_i = 1'b0;
    tick();
    cnt = 0;
    while (busy_o && cnt < 20) begin
      cnt++;
      tick();
    end
    exp_rdata = 32'hBAD0_BAD0;
    exp_err = 1'b1;
    n_checks++;
    if (cnt !== TO || rdata_o !== exp_rdata) begin
      n_fail++;
      $display("FAIL timeout cycles=%0d rdata=%h exp %0d %h",
               cnt, rdata_o, TO, exp_rdata);
    end
    rwi = 2'b00;
    tick(); tick(); tick();
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%b exp=1", err_o);
    end
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    exp_rdata = '0; exp_fetch = 1'b0; exp_err = 1'b0;
    tick();
    do_txn(2'b10, 32'h6004, $urandom, 32'h7777_0001, TO - 1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_immediate();
    test_write_delayed();
    test_held_request();
    test_addr_change();
    test_reset_mid();
    test_random();
`ifdef T07_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
